prng_scrambler: RTL and testbench
=================================

# prng_scrambler

Parametrised pseudo-random byte generator: a DATA_W-bit data LFSR and a CTRL_W-bit control LFSR feed a pair-select scrambler that produces an OUT_W-bit registered random word. The block runs entirely on the system clock and uses a prescaler-generated tick enable instead of derived clocks. It adds seed loading, single-step and hold modes, and all-ones lock-up protection. It sits between the top-level I/O and the 7-segment decoders; rnd_out feeds the two hex digits.

## Interface
- DATA_W, 16: data LFSR width; legal values 8, 16, 32
- CTRL_W, DATA_W/2: control LFSR width, equal to OUT_W (derived, not overridable)
- DIV, 10_000_000: clk cycles per free-run tick; ≥1
- RATIO, 4: control steps per data step; ≥1

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- en  in  1  block enable; low = hold and clear prescaler
- mode  in  2  00 free-run, 01 single-step, 10/11 hold
- step  in  1  one advance per high cycle in single-step mode
- seed_load  in  1  load seed_data this cycle
- seed_data  in  DATA_W  seed; low CTRL_W bits also seed the control LFSR
- rnd_out  out  DATA_W/2  scrambled word, registered
- rnd_valid  out  1  one-cycle pulse on every rnd_out update
- lock_err  out  1  one-cycle pulse when a seed was all-ones and got replaced

## Operation
- Both LFSRs are Fibonacci with XNOR feedback. Each step shifts left and inserts feedback at bit 0. All-zero is legal. All-ones is the lock-up state.
- Taps by width (bit indices): 8 → 7,5,4,3; 16 → 15,14,12,3; 32 → 31,21,1,0.
- Tick sources:
  - free-run: prescaler counts 0..DIV-1; tick fires when count = DIV-1, then wraps to 0
  - single-step: tick = step; prescaler held at 0
  - hold, or en=0: no tick; en=0 also clears the prescaler
- On each tick:
  - control LFSR steps
  - ratio counter advances 0..RATIO-1
  - data LFSR steps only on the tick where ratio counter = RATIO-1, then the counter wraps
- Scrambler: bit j of the word = ctrl[j] ? data[2j+1] : data[2j], for j = 0..OUT_W-1.
- Seed load:
  - data ← seed_data; ctrl ← seed_data[CTRL_W-1:0]
  - prescaler and ratio counter cleared
  - a value that is all-ones in its own width is replaced by 0, and lock_err pulses
- Priority: reset > seed_load > tick. A tick coinciding with seed_load is discarded.
- Reset values: LFSRs 0, prescaler 0, ratio counter 0, rnd_out 0, rnd_valid 0, lock_err 0.

## Timing
- An update event (tick or seed_load) sampled at edge k changes LFSR state after edge k.
- At edge k+1, rnd_out ← scramble(state) and rnd_valid is high for exactly one cycle. Latency from the sampled input to rnd_valid is 2 cycles.
- lock_err asserts in the same cycle as rnd_valid for that load.
- Back-to-back step cycles give back-to-back rnd_valid pulses; there is no throughput limit.
- reset mid-operation: all state returns to reset values at the next edge. A pending rnd_valid is cancelled.
- mode change takes effect on the next edge. Switching into free-run keeps the current prescaler count, which is 0 coming from step mode.
- DIV=1: a tick fires every cycle in free-run.

## Structure
- Package prng_pkg:
  - mode encodings
  - tap-mask function of width (8/16/32)
  - all-ones check function
- Sub-module prng_lfsr: parameters WIDTH and TAPS; ports load, load_val, advance, state. Instantiated twice.
- Prescaler, ratio counter, scrambler and output register live in prng_scrambler.

## Test plan
All cases use DATA_W=16, DIV=4, RATIO=4.
1. Reset, then mode=00, en=1 for 64 cycles → 16 rnd_valid pulses, exactly 4 cycles apart. After 4 ticks: ctrl = 8'h0F, data = 16'h0001.
2. mode=01; four step pulses → ctrl goes 01, 03, 07, 0F. Data goes 0000 → 0001 on the 4th step only. rnd_valid pulses 2 cycles after each step.
3. seed_load with seed_data = 16'hA5A5 → two cycles later rnd_out = 8'h96, rnd_valid = 1, lock_err = 0.
4. seed_load with 16'hFFFF → data = 0000, ctrl = 00, rnd_out = 8'h00, lock_err pulses with rnd_valid.
5. seed_load and step in the same cycle (mode=01) → seed wins. The step is dropped, and exactly one rnd_valid pulse occurs.
6. Free-running with prescaler count at 2, assert reset for 1 cycle → all outputs 0 at the next edge. The first tick comes DIV cycles after reset deasserts. mode=10 or en=0 → no rnd_valid for 100 cycles.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared encodings and helpers for the PRNG scrambler.
package prng_pkg;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_STEP     = 2'b01,
    MODE_HOLD     = 2'b10,
    MODE_HOLD_ALT = 2'b11
  } mode_e;

  // XNOR tap masks; the 4-bit entry serves the control LFSR of an 8-bit data path.
  function automatic logic [31:0] tap_mask(input int width);
    case (width)
      4:       return 32'h0000_000C;
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_D008;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic is_all_ones(input logic [31:0] value, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value & mask) == mask;
  endfunction

endpackage

// File: rtl/prng_lfsr.sv
// Fibonacci XNOR LFSR, shift-left with feedback into bit 0.
// Latency: state changes the edge after load/advance is sampled.
// Backpressure: none; load takes priority over advance.
module prng_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  logic feedback;

  assign feedback = ~(^(state & TAPS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
    end else if (load) begin
      state <= load_val;
    end else if (advance) begin
      state <= {state[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/prng_scrambler.sv
// Prescaled dual-LFSR random word generator with pair-select scrambling.
// Latency: update sampled at edge k -> rnd_out/rnd_valid after edge k+1.
// Backpressure: none; every update produces a one-cycle rnd_valid pulse.
module prng_scrambler
  import prng_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV    = 10_000_000,
  parameter int RATIO  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                step,
  input  logic                seed_load,
  input  logic [DATA_W-1:0]   seed_data,
  output logic [DATA_W/2-1:0] rnd_out,
  output logic                rnd_valid,
  output logic                lock_err
);

  localparam int CTRL_W = DATA_W / 2;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RAT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [RAT_W-1:0]  RAT_LAST   = RAT_W'(RATIO - 1);
  localparam logic [DATA_W-1:0] DATA_TAPS  = DATA_W'(tap_mask(DATA_W));
  localparam logic [CTRL_W-1:0] CTRL_TAPS  = CTRL_W'(tap_mask(CTRL_W));

  mode_e             mode_s;
  logic [PRE_W-1:0]  pre_cnt;
  logic [RAT_W-1:0]  ratio_cnt;
  logic              pre_wrap;
  logic              tick;
  logic              ctrl_adv;
  logic              data_adv;
  logic              data_lock;
  logic              ctrl_lock;
  logic [DATA_W-1:0] data_seed;
  logic [CTRL_W-1:0] ctrl_seed;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] scrambled;
  logic              upd_pend;
  logic              lock_pend;

  assign mode_s   = mode_e'(mode);
  assign pre_wrap = (pre_cnt == PRE_LAST);

  always_comb begin
    tick = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_FREE: tick = pre_wrap;
        MODE_STEP: tick = step;
        default:   tick = 1'b0;
      endcase
    end
  end

  // A tick that lands on a seed load is dropped entirely, ratio counter included.
  assign ctrl_adv = tick & ~seed_load;
  assign data_adv = ctrl_adv & (ratio_cnt == RAT_LAST);

  assign data_lock = is_all_ones(32'(seed_data), DATA_W);
  assign ctrl_lock = is_all_ones(32'(seed_data[CTRL_W-1:0]), CTRL_W);
  assign data_seed = data_lock ? '0 : seed_data;
  assign ctrl_seed = ctrl_lock ? '0 : seed_data[CTRL_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (seed_load || !en || mode_s == MODE_STEP) begin
      pre_cnt <= '0;
    end else if (mode_s == MODE_FREE) begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || seed_load) begin
      ratio_cnt <= '0;
    end else if (ctrl_adv) begin
      ratio_cnt <= (ratio_cnt == RAT_LAST) ? '0 : ratio_cnt + 1'b1;
    end
  end

  prng_lfsr #(
    .WIDTH (DATA_W),
    .TAPS  (DATA_TAPS)
  ) u_data (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (data_seed),
    .advance  (data_adv),
    .state    (data_q)
  );

  prng_lfsr #(
    .WIDTH (CTRL_W),
    .TAPS  (CTRL_TAPS)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (ctrl_seed),
    .advance  (ctrl_adv),
    .state    (ctrl_q)
  );

  always_comb begin
    scrambled = '0;
    for (int j = 0; j < CTRL_W; j++) begin
      scrambled[j] = ctrl_q[j] ? data_q[2*j+1] : data_q[2*j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_pend  <= 1'b0;
      lock_pend <= 1'b0;
      rnd_valid <= 1'b0;
      lock_err  <= 1'b0;
      rnd_out   <= '0;
    end else begin
      upd_pend  <= seed_load | tick;
      lock_pend <= seed_load & (data_lock | ctrl_lock);
      rnd_valid <= upd_pend;
      lock_err  <= lock_pend;
      if (upd_pend) begin
        rnd_out <= scrambled;
      end
    end
  end

endmodule

// File: tb/tb_prng_scrambler.sv
// Randomized scoreboard bench for prng_scrambler (DATA_W=16, DIV=4, RATIO=4).
module tb_prng_scrambler;

  localparam int DIV   = 4;
  localparam int RATIO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic        step;
  logic        seed_load;
  logic [15:0] seed_data;
  logic [7:0]  rnd_out;
  logic        rnd_valid;
  logic        lock_err;

  prng_scrambler #(.DATA_W(16), .DIV(DIV), .RATIO(RATIO)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .step      (step),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .rnd_out   (rnd_out),
    .rnd_valid (rnd_valid),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       lock;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   edge_cnt  = 0;
  int   valid_cnt = 0;
  bit   mon_on    = 0;

  // Reference state: plain integers, advanced by the behavioural rules.
  int m_data = 0, m_ctrl = 0, m_pre = 0, m_ticks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int lfsr_next(input int s, input int w);
    int taps[4];
    int ones;
    ones = 0;
    if (w == 8) taps = '{7, 5, 4, 3};
    else        taps = '{15, 14, 12, 3};
    foreach (taps[i]) ones += (s >> taps[i]) & 1;
    return ((s << 1) | ((ones % 2 == 0) ? 1 : 0)) & ((1 << w) - 1);
  endfunction

  function automatic logic [7:0] scramble(input int d, input int c);
    logic [7:0] o;
    o = '0;
    for (int j = 0; j < 8; j++) o[j] = 1'((d >> (2 * j + ((c >> j) & 1))) & 1);
    return o;
  endfunction

  task automatic push(input logic lk, input int due);
    exp_t e;
    e.out  = scramble(m_data, m_ctrl);
    e.lock = lk;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic model_edge();
    int  k;
    bit  t;
    bit  dl, cl;
    k = edge_cnt + 1;
    if (reset) begin
      m_data = 0; m_ctrl = 0; m_pre = 0; m_ticks = 0;
      while (sb.size() > 0 && sb[$].due >= k) void'(sb.pop_back());
    end else if (seed_load) begin
      dl = (seed_data == 16'hFFFF);
      cl = (seed_data[7:0] == 8'hFF);
      m_data  = dl ? 0 : int'(seed_data);
      m_ctrl  = cl ? 0 : int'(seed_data[7:0]);
      m_pre   = 0;
      m_ticks = 0;
      push(dl | cl, k + 1);
    end else begin
      t = 0;
      if (en && mode == 2'b00) t = (m_pre == DIV - 1);
      if (en && mode == 2'b01) t = step;
      if (!en || mode == 2'b01) m_pre = 0;
      else if (mode == 2'b00)   m_pre = (m_pre + 1) % DIV;
      if (t) begin
        m_ctrl = lfsr_next(m_ctrl, 8);
        m_ticks++;
        if (m_ticks % RATIO == 0) m_data = lfsr_next(m_data, 16);
        push(1'b0, k + 1);
      end
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic s, input logic sl, input logic [15:0] sd);
    reset = r; en = e; mode = m; step = s; seed_load = sl; seed_data = sd;
    model_edge();
    @(posedge clk);
    edge_cnt++;
    #2;
  endtask

  task automatic idle(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) drive(0, 1, m, 0, 0, 16'h0000);
  endtask

  // Monitor: every cycle, compare rnd_valid/rnd_out/lock_err with the scoreboard head.
  always @(negedge clk) begin
    if (mon_on) begin
      bit   exp_v;
      exp_t e;
      exp_v = (sb.size() > 0 && sb[0].due == edge_cnt);
      check("rnd_valid", 32'(rnd_valid), 32'(exp_v));
      if (exp_v) begin
        e = sb.pop_front();
        check("rnd_out", 32'(rnd_out), 32'(e.out));
        check("lock_err", 32'(lock_err), 32'(e.lock));
      end else begin
        check("lock_err_idle", 32'(lock_err), 32'(1'b0));
      end
      if (rnd_valid === 1'b1) valid_cnt++;
    end
  end

  initial begin
    logic [7:0]  c_tab[4];
    logic [15:0] d_tab[4];
    int          snap;
    logic        r, sl, s, e;
    logic [1:0]  m;
    logic [15:0] sd;

    c_tab = '{8'h01, 8'h03, 8'h07, 8'h0F};
    d_tab = '{16'h0000, 16'h0000, 16'h0000, 16'h0001};

    reset = 1; en = 0; mode = 2'b10; step = 0; seed_load = 0; seed_data = '0;
    @(posedge clk); #2;
    drive(1, 0, 2'b10, 0, 0, 16'h0000);
    drive(1, 0, 2'b10, 0, 0, 16'h0000);
    mon_on = 1;
    check("reset_rnd_out", 32'(rnd_out), 32'h0);
    check("reset_rnd_valid", 32'(rnd_valid), 32'h0);
    check("reset_lock_err", 32'(lock_err), 32'h0);

    // 1: free-run, tick every DIV cycles
    snap = valid_cnt;
    idle(16, 2'b00);
    check("free_ctrl_4ticks", 32'(dut.ctrl_q), 32'h0F);
    check("free_data_4ticks", 32'(dut.data_q), 32'h0001);
    idle(48, 2'b00);
    idle(3, 2'b10);
    check("free_pulse_count", 32'(valid_cnt - snap), 32'd16);

    // 2: single-step from reset
    drive(1, 1, 2'b01, 0, 0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 2'b01, 1, 0, 16'h0000);
      check("step_ctrl", 32'(dut.ctrl_q), 32'(c_tab[i]));
      check("step_data", 32'(dut.data_q), 32'(d_tab[i]));
      idle(1, 2'b01);
    end
    idle(2, 2'b01);

    // 3/4: seed loads, ordinary and lock-up
    drive(0, 1, 2'b01, 0, 1, 16'hA5A5);
    idle(1, 2'b01);
    check("seed_a5a5_out", 32'(rnd_out), 32'h96);
    check("seed_a5a5_vld", 32'(rnd_valid), 32'h1);
    check("seed_a5a5_lock", 32'(lock_err), 32'h0);
    drive(0, 1, 2'b01, 0, 1, 16'hFFFF);
    check("lockup_data", 32'(dut.data_q), 32'h0);
    check("lockup_ctrl", 32'(dut.ctrl_q), 32'h0);
    idle(1, 2'b01);
    check("lockup_out", 32'(rnd_out), 32'h00);
    check("lockup_lock", 32'(lock_err), 32'h1);
    idle(2, 2'b01);

    // 5: seed wins over a coincident step
    snap = valid_cnt;
    drive(0, 1, 2'b01, 1, 1, 16'h3C5A);
    idle(3, 2'b01);
    check("seed_step_pulses", 32'(valid_cnt - snap), 32'd1);
    check("seed_step_ctrl", 32'(dut.ctrl_q), 32'h5A);
    check("seed_step_data", 32'(dut.data_q), 32'h3C5A);

    // 6: reset mid free-run, then hold and disable windows
    drive(0, 1, 2'b00, 0, 1, 16'hA5A5);
    idle(2, 2'b00);
    check("pre_before_reset", 32'(dut.pre_cnt), 32'd2);
    drive(1, 1, 2'b00, 0, 0, 16'h0000);
    check("midreset_out", 32'(rnd_out), 32'h0);
    check("midreset_vld", 32'(rnd_valid), 32'h0);
    check("midreset_lock", 32'(lock_err), 32'h0);
    idle(8, 2'b00);
    idle(2, 2'b10);
    snap = valid_cnt;
    idle(100, 2'b10);
    check("hold_quiet", 32'(valid_cnt - snap), 32'd0);
    snap = valid_cnt;
    for (int i = 0; i < 100; i++) drive(0, 0, 2'b00, 1, 0, 16'h0000);
    check("disable_quiet", 32'(valid_cnt - snap), 32'd0);

    // Randomized mix against the reference model
    m = 2'b00;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      e  = ($urandom_range(0, 9) != 0);
      s  = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: m = 2'b00;
          5, 6, 7:       m = 2'b01;
          default:       m = 2'($urandom_range(2, 3));
        endcase
      end
      case ($urandom_range(0, 3))
        0:       sd = 16'hFFFF;
        1:       sd = {8'($urandom_range(0, 255)), 8'hFF};
        default: sd = 16'($urandom_range(0, 65535));
      endcase
      drive(r, e, m, s, sl, sd);
    end
    idle(4, 2'b10);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
